// File: rtl/da_stdp_reward_synapse_if.sv
// da_stdp_reward_synapse_if: spike/reward inputs and synapse outputs between driver and synapse
interface da_stdp_reward_synapse_if;
  logic pre_spike, post_spike, reward, prediction;
  logic [1:0] dopamine_level;
  logic [7:0] weighted_current, weight;
  modport master(output pre_spike, post_spike, reward,
                 input dopamine_level, prediction, weighted_current, weight);
  modport slave(input pre_spike, post_spike, reward,
                output dopamine_level, prediction, weighted_current, weight);
endinterface

// File: rtl/da_stdp_reward_synapse.sv
// da_stdp_reward_synapse: trace-based STDP synapse whose LTP/LTD steps are scaled by a reward-predicted dopamine level
module da_stdp_reward_synapse #(
  parameter logic [3:0] PREDICT_THRESH = 4'd4,
  parameter logic [7:0] INIT_WEIGHT = 8'd10,
  parameter logic [7:0] LTP_STEP = 8'd3,
  parameter logic [7:0] LTD_STEP = 8'd1,
  parameter logic [3:0] TRACE_DECAY = 4'd8
) (
  input logic clk,
  input logic rst_n,
  da_stdp_reward_synapse_if.slave bus
);
  logic [3:0] cnt_q, cnt_d, pre_tr_q, pre_tr_d, post_tr_q, post_tr_d;
  logic pred_q, pred_d, ltp, ltd;
  logic [7:0] weight_q, weight_d;
  logic [1:0] da;
  logic [9:0] ltp_eff, ltd_eff, sum;
  always_comb begin
    cnt_d = bus.reward ? cnt_q + {3'd0, cnt_q != 4'd15} : cnt_q - {3'd0, cnt_q != 4'd0};
    pred_d = cnt_d >= PREDICT_THRESH;
    da = bus.reward ? (pred_q ? 2'b01 : 2'b11) : (pred_q ? 2'b00 : 2'b01);
    ltp_eff = da == 2'b11 ? 10'(LTP_STEP) * 10'd3 :
              da == 2'b10 ? {1'b0, LTP_STEP, 1'b0} :
              da == 2'b01 ? {2'b00, LTP_STEP} : {3'b000, LTP_STEP[7:1]};
    ltd_eff = da == 2'b00 ? {1'b0, LTD_STEP, 1'b0} : {2'b00, LTD_STEP};
    pre_tr_d = bus.pre_spike ? TRACE_DECAY : pre_tr_q - {3'd0, pre_tr_q != 4'd0};
    post_tr_d = bus.post_spike ? TRACE_DECAY : post_tr_q - {3'd0, post_tr_q != 4'd0};
    // traces sampled before the edge, so a coincident pre/post pair never updates the weight
    ltp = bus.post_spike & ~bus.pre_spike & (pre_tr_q != 4'd0);
    ltd = bus.pre_spike & ~bus.post_spike & (post_tr_q != 4'd0);
    sum = {2'b00, weight_q} + ltp_eff;
    weight_d = ltp ? (sum > 10'd255 ? 8'hFF : sum[7:0]) :
               ltd ? (ltd_eff > {2'b00, weight_q} ? 8'h00 : weight_q - ltd_eff[7:0]) : weight_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pred_q <= 1'b0;
      pre_tr_q <= '0;
      post_tr_q <= '0;
      weight_q <= INIT_WEIGHT;
    end else begin
      cnt_q <= cnt_d;
      pred_q <= pred_d;
      pre_tr_q <= pre_tr_d;
      post_tr_q <= post_tr_d;
      weight_q <= weight_d;
    end
  end
  assign bus.dopamine_level = da;
  assign bus.prediction = pred_q;
  assign bus.weight = weight_q;
  assign bus.weighted_current = bus.pre_spike ? weight_q : 8'd0;
endmodule

// File: tb/tb_da_stdp_reward_synapse.sv
// tb_da_stdp_reward_synapse: directed vectors with hand-computed weights, dopamine and prediction
module tb_da_stdp_reward_synapse;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_pass = 0;
  da_stdp_reward_synapse_if bus();
  da_stdp_reward_synapse dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input logic p, input logic q);
    bus.pre_spike = p;
    bus.post_spike = q;
    @(posedge clk);
    #1;
    bus.pre_spike = 1'b0;
    bus.post_spike = 1'b0;
  endtask
  task automatic do_reset(input logic r);
    bus.pre_spike = 1'b0;
    bus.post_spike = 1'b0;
    bus.reward = r;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic pattern();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask
  initial begin
    bus.pre_spike = 1'b0;
    bus.post_spike = 1'b0;
    bus.reward = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_weight", int'(bus.weight), 10);
    check("rst_dopamine", int'(bus.dopamine_level), 1);
    check("rst_prediction", int'(bus.prediction), 0);
    check("rst_current", int'(bus.weighted_current), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pattern();
    check("pat_first", int'(bus.weight), 13);
    repeat (9) pattern();
    check("pat_final", int'(bus.weight), 31);
    bus.pre_spike = 1'b1;
    #1;
    check("current_pre", int'(bus.weighted_current), 31);
    bus.pre_spike = 1'b0;
    #1;
    check("current_idle", int'(bus.weighted_current), 0);
    do_reset(1'b1);
    check("rew_burst", int'(bus.dopamine_level), 3);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("rew_ltp9", int'(bus.weight), 19);
    tick(1'b0, 1'b0);
    check("rew_pred_e3", int'(bus.prediction), 0);
    check("rew_da_e3", int'(bus.dopamine_level), 3);
    tick(1'b0, 1'b0);
    check("rew_pred_e4", int'(bus.prediction), 1);
    check("rew_da_e4", int'(bus.dopamine_level), 1);
    tick(1'b0, 1'b1);
    check("rew_ltp3", int'(bus.weight), 22);
    repeat (12) tick(1'b0, 1'b0);
    bus.reward = 1'b0;
    #1;
    check("sup_da", int'(bus.dopamine_level), 0);
    pattern();
    check("sup_p1", int'(bus.weight), 23);
    pattern();
    check("sup_p2", int'(bus.weight), 22);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("sup_pred_e11", int'(bus.prediction), 1);
    check("sup_w_e11", int'(bus.weight), 21);
    tick(1'b0, 1'b0);
    check("sup_pred_e12", int'(bus.prediction), 0);
    check("sup_da_e12", int'(bus.dopamine_level), 1);
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      repeat (8) tick(1'b0, 1'b1);
      repeat (8) tick(1'b0, 1'b0);
    end
    check("sat_pump", int'(bus.weight), 250);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("sat_254", int'(bus.weight), 254);
    bus.reward = 1'b1;
    #1;
    check("sat_da_burst", int'(bus.dopamine_level), 3);
    tick(1'b0, 1'b1);
    check("sat_top", int'(bus.weight), 255);
    tick(1'b0, 1'b1);
    check("sat_top_hold", int'(bus.weight), 255);
    bus.reward = 1'b0;
    for (int i = 0; i < 31; i++) begin
      tick(1'b1, 1'b1);
      repeat (8) tick(1'b1, 1'b0);
    end
    check("sat_drain", int'(bus.weight), 7);
    tick(1'b1, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    check("sat_one", int'(bus.weight), 1);
    bus.reward = 1'b1;
    repeat (8) tick(1'b0, 1'b0);
    bus.reward = 1'b0;
    #1;
    check("sat_da_sup", int'(bus.dopamine_level), 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check("sat_bottom", int'(bus.weight), 0);
    tick(1'b1, 1'b0);
    check("sat_bottom_hold", int'(bus.weight), 0);
    do_reset(1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("co_pre", int'(bus.weight), 13);
    tick(1'b1, 1'b1);
    check("co_both", int'(bus.weight), 13);
    tick(1'b1, 1'b0);
    check("co_ltd", int'(bus.weight), 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_weight", int'(bus.weight), 10);
    check("async_pred", int'(bus.prediction), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b1);
    check("post_after_rst", int'(bus.weight), 10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
